trace_stream_frontend: RTL and testbench

TRACE_STREAM_FRONTEND -- requirements
Module: trace_stream_frontend

---
 rtl/trace_stream_frontend.sv | 125 ++++++++++++
 tb/tb_trace_stream_frontend.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_stream_frontend.sv
// rtl/trace_stream_frontend.sv - trace front end: strobe edge detect, event counters, one-deep AXI-Stream output register
//
// Ports
//   clk                 rising-edge clock for all state
//   rst                 synchronous active-high reset
//   sig                 level input to edge-detect
//   sig_pos_edge        sig is 1 now and was 0 last cycle
//   sig_neg_edge        sig is 0 now and was 1 last cycle
//   performance_events  one bit per event, high = event occurs this cycle
//   counters_clear      synchronous clear of all event counters
//   counters            packed counters, counter i at [i*COUNTER_WIDTH +: COUNTER_WIDTH]
//   write_enable        push data_pkt to the stream this cycle
//   data_pkt            packet captured on write_enable
//   tlast_interval      items per packet, 0 disables interval-based tlast
//   tlast               force tlast on the item written this cycle
//   M_AXIS_tvalid       stream valid
//   M_AXIS_tready       stream ready
//   M_AXIS_tdata        stream data
//   M_AXIS_tlast        stream last
//   overflow            sticky: a write was dropped because the register was full

module trace_stream_frontend #(
   parameter int NUM_EVENTS    = 37,
   parameter int COUNTER_WIDTH = 7,
   parameter int DATA_WIDTH    = 512
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                sig,
   output logic                                sig_pos_edge,
   output logic                                sig_neg_edge,
   input  logic [NUM_EVENTS-1:0]               performance_events,
   input  logic                                counters_clear,
   output logic [NUM_EVENTS*COUNTER_WIDTH-1:0] counters,
   input  logic                                write_enable,
   input  logic [DATA_WIDTH-1:0]               data_pkt,
   input  logic [31:0]                         tlast_interval,
   input  logic                                tlast,
   output logic                                M_AXIS_tvalid,
   input  logic                                M_AXIS_tready,
   output logic [DATA_WIDTH-1:0]               M_AXIS_tdata,
   output logic                                M_AXIS_tlast,
   output logic                                overflow
);

   // ------------------------------------------------------------------
   // Edge detector
   // ------------------------------------------------------------------
   logic prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev <= 1'b0;
      end else begin
         prev <= sig;
      end
   end

   // Combinational from the live input so the edge is visible in the
   // same cycle sig changes.
   assign sig_pos_edge = sig & ~prev;
   assign sig_neg_edge = ~sig & prev;

   // ------------------------------------------------------------------
   // Event counters
   // ------------------------------------------------------------------
   logic [COUNTER_WIDTH-1:0] cnt [NUM_EVENTS];

   for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_counter
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt[i] <= '0;
         end else if (counters_clear) begin
            // Load the event bit so an event in the clear cycle is counted.
            cnt[i] <= {{(COUNTER_WIDTH-1){1'b0}}, performance_events[i]};
         end else if (performance_events[i]) begin
            cnt[i] <= cnt[i] + 1'b1;
         end
      end

      assign counters[i*COUNTER_WIDTH +: COUNTER_WIDTH] = cnt[i];
   end

   // ------------------------------------------------------------------
   // Stream output register
   // ------------------------------------------------------------------
   logic        xfer;
   logic        accept;
   logic        item_last;
   logic [31:0] item_count;

   // The register frees up in the same cycle its item is taken, so a
   // write can land back-to-back with a completing transfer. tvalid itself
   // is purely registered; tready only steers the next state.
   assign xfer   = M_AXIS_tvalid & M_AXIS_tready;
   assign accept = write_enable & (~M_AXIS_tvalid | M_AXIS_tready);

   assign item_last = tlast |
                      ((tlast_interval != 32'd0) && (item_count == tlast_interval - 32'd1));

   always_ff @(posedge clk) begin
      if (rst) begin
         M_AXIS_tvalid <= 1'b0;
         M_AXIS_tdata  <= '0;
         M_AXIS_tlast  <= 1'b0;
         item_count    <= 32'd0;
         overflow      <= 1'b0;
      end else begin
         if (accept) begin
            M_AXIS_tvalid <= 1'b1;
            M_AXIS_tdata  <= data_pkt;
            M_AXIS_tlast  <= item_last;
            item_count    <= item_last ? 32'd0 : item_count + 32'd1;
         end else if (xfer) begin
            M_AXIS_tvalid <= 1'b0;
         end

         // Full and not draining: the write is lost and the count untouched.
         if (write_enable && !accept) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_trace_stream_frontend.sv
// tb/tb_trace_stream_frontend.sv - self-checking bench for trace_stream_frontend

module tb_trace_stream_frontend;

   localparam int NE = 37;
   localparam int CW = 7;
   localparam int DW = 512;

   logic              clk = 1'b0;
   logic              rst;
   logic              sig;
   logic              sig_pos_edge;
   logic              sig_neg_edge;
   logic [NE-1:0]     performance_events;
   logic              counters_clear;
   logic [NE*CW-1:0]  counters;
   logic              write_enable;
   logic [DW-1:0]     data_pkt;
   logic [31:0]       tlast_interval;
   logic              tlast_in;
   logic              M_AXIS_tvalid;
   logic              M_AXIS_tready;
   logic [DW-1:0]     M_AXIS_tdata;
   logic              M_AXIS_tlast;
   logic              overflow;

   trace_stream_frontend #(
      .NUM_EVENTS(NE), .COUNTER_WIDTH(CW), .DATA_WIDTH(DW)
   ) dut (
      .clk(clk), .rst(rst), .sig(sig),
      .sig_pos_edge(sig_pos_edge), .sig_neg_edge(sig_neg_edge),
      .performance_events(performance_events), .counters_clear(counters_clear),
      .counters(counters), .write_enable(write_enable), .data_pkt(data_pkt),
      .tlast_interval(tlast_interval), .tlast(tlast_in),
      .M_AXIS_tvalid(M_AXIS_tvalid), .M_AXIS_tready(M_AXIS_tready),
      .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tlast(M_AXIS_tlast),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } item_t;

   // Reference model: accepted items waiting to be taken, items seen leaving
   // the DUT, counter values as integers, and the packet position.
   item_t       sb[$];
   item_t       obs_q[$];
   int          m_cnt [NE];
   logic        m_prev;
   logic        m_ovf;
   logic [31:0] m_items;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_counters();
      logic [DW-1:0] r;
      r = '0;
      for (int i = 0; i < NE; i++) r[i*CW +: CW] = m_cnt[i][CW-1:0];
      return r;
   endfunction

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] r;
      for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // One clock: check every output against the model at the negedge, then
   // advance the model using the inputs the caller has set.
   task automatic tick();
      item_t it;
      @(negedge clk);
      chk("sig_pos_edge", sig_pos_edge, sig & ~m_prev);
      chk("sig_neg_edge", sig_neg_edge, ~sig & m_prev);
      chk("tvalid", M_AXIS_tvalid, sb.size() != 0);
      if (sb.size() != 0) begin
         chk("tdata", M_AXIS_tdata, sb[0].d);
         chk("tlast", M_AXIS_tlast, sb[0].l);
      end
      chk("overflow", overflow, m_ovf);
      chk("counters", counters, exp_counters());

      if (rst) begin
         sb.delete();
         m_ovf   = 1'b0;
         m_items = 32'd0;
         m_prev  = 1'b0;
         for (int i = 0; i < NE; i++) m_cnt[i] = 0;
      end else begin
         if (M_AXIS_tvalid && M_AXIS_tready) begin
            it.d = M_AXIS_tdata;
            it.l = M_AXIS_tlast;
            obs_q.push_back(it);
         end
         if (sb.size() != 0 && M_AXIS_tready) void'(sb.pop_front());
         for (int i = 0; i < NE; i++) begin
            if (counters_clear) m_cnt[i] = performance_events[i] ? 1 : 0;
            else if (performance_events[i]) m_cnt[i] = (m_cnt[i] + 1) % (1 << CW);
         end
         if (write_enable) begin
            if (sb.size() == 0) begin
               it.d = data_pkt;
               it.l = tlast_in || (tlast_interval != 0 && m_items == tlast_interval - 1);
               sb.push_back(it);
               m_items = it.l ? 32'd0 : m_items + 32'd1;
            end else begin
               m_ovf = 1'b1;
            end
         end
         m_prev = sig;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      sig = 1'b0; performance_events = '0; counters_clear = 1'b0;
      write_enable = 1'b0; data_pkt = '0; tlast_in = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      obs_q.delete();
   endtask

   int ep [6] = '{0, 0, 1, 0, 0, 0};
   int en [6] = '{0, 0, 0, 0, 0, 1};
   int sv [6] = '{0, 0, 1, 1, 1, 0};
   logic [DW-1:0] a_pkt, b_pkt;

   initial begin
      rst = 1'b1;
      idle_inputs();
      tlast_interval = 32'd0;
      M_AXIS_tready  = 1'b0;
      m_prev = 1'b0; m_ovf = 1'b0; m_items = 32'd0;
      for (int i = 0; i < NE; i++) m_cnt[i] = 0;

      // Reset state, with inputs active during reset being ignored.
      performance_events = '1; counters_clear = 1'b1; write_enable = 1'b1;
      data_pkt = rnd_data(); sig = 1'b1;
      tick();
      tick();
      chk("rst_tvalid", M_AXIS_tvalid, 1'b0);
      chk("rst_tdata", M_AXIS_tdata, '0);
      chk("rst_tlast", M_AXIS_tlast, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_counters", counters, '0);

      // sig high in the first cycle after reset release.
      idle_inputs();
      rst = 1'b0;
      sig = 1'b1;
      #1;
      chk("first_cycle_pos_edge", sig_pos_edge, 1'b1);
      tick();
      sig = 1'b0;
      tick();

      // Edge pattern 0,0,1,1,1,0.
      for (int k = 0; k < 6; k++) begin
         sig = sv[k][0];
         #1;
         chk("seq_pos_edge", sig_pos_edge, ep[k][0]);
         chk("seq_neg_edge", sig_neg_edge, en[k][0]);
         tick();
      end
      sig = 1'b0;

      // Counter wrap and clear-with-event.
      do_reset();
      performance_events = '0;
      performance_events[0] = 1'b1;
      for (int k = 0; k < 130; k++) tick();
      performance_events = '0;
      chk("counter0_wrap", counters[CW-1:0], 7'd2);
      chk("counter1_idle", counters[2*CW-1:CW], 7'd0);
      counters_clear = 1'b1;
      performance_events[0] = 1'b1;
      tick();
      counters_clear = 1'b0;
      performance_events = '0;
      chk("counter0_clear_event", counters[CW-1:0], 7'd1);

      // Back-to-back writes 1..9, interval 4.
      do_reset();
      M_AXIS_tready = 1'b1;
      tlast_interval = 32'd4;
      for (int k = 1; k <= 9; k++) begin
         write_enable = 1'b1;
         data_pkt = DW'(k);
         tick();
      end
      write_enable = 1'b0;
      tick();
      tick();
      chk("b2b_count", DW'(obs_q.size()), DW'(9));
      for (int k = 0; k < obs_q.size() && k < 9; k++) begin
         chk("b2b_tdata", obs_q[k].d, DW'(k + 1));
         chk("b2b_tlast", obs_q[k].l, (k == 3 || k == 7));
      end

      // Overflow: A held, B dropped.
      do_reset();
      M_AXIS_tready = 1'b0;
      a_pkt = rnd_data();
      b_pkt = ~a_pkt;
      write_enable = 1'b1; data_pkt = a_pkt;
      tick();
      data_pkt = b_pkt;
      tick();
      write_enable = 1'b0;
      tick();
      chk("ovf_hold_tdata", M_AXIS_tdata, a_pkt);
      chk("ovf_flag", overflow, 1'b1);
      M_AXIS_tready = 1'b1;
      tick();
      chk("ovf_tvalid_drop", M_AXIS_tvalid, 1'b0);
      tick();
      tick();
      chk("ovf_one_item", DW'(obs_q.size()), DW'(1));
      if (obs_q.size() > 0) chk("ovf_item_is_a", obs_q[0].d, a_pkt);
      chk("ovf_sticky", overflow, 1'b1);

      // Forced tlast with interval 0, then interval count restarts.
      do_reset();
      M_AXIS_tready = 1'b1;
      tlast_interval = 32'd0;
      for (int k = 1; k <= 5; k++) begin
         write_enable = 1'b1;
         data_pkt = DW'(k);
         tlast_in = (k == 3);
         if (k == 4) tlast_interval = 32'd2;
         tick();
      end
      write_enable = 1'b0; tlast_in = 1'b0;
      tick();
      tick();
      chk("force_count", DW'(obs_q.size()), DW'(5));
      for (int k = 0; k < obs_q.size() && k < 5; k++)
         chk("force_tlast", obs_q[k].l, (k == 2 || k == 4));

      // Reset while an item is stalled.
      do_reset();
      M_AXIS_tready = 1'b0;
      performance_events = '1;
      write_enable = 1'b1; data_pkt = rnd_data();
      tick();
      write_enable = 1'b1; data_pkt = rnd_data();
      tick();
      write_enable = 1'b0; performance_events = '0;
      chk("stall_tvalid", M_AXIS_tvalid, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_stall_tvalid", M_AXIS_tvalid, 1'b0);
      chk("rst_stall_overflow", overflow, 1'b0);
      chk("rst_stall_counters", counters, '0);

      // Randomized traffic against the model.
      for (int k = 0; k < 1500; k++) begin
         if (k % 60 == 0) tlast_interval = 32'($urandom_range(0, 5));
         rst                = ($urandom_range(0, 99) == 0);
         sig                = $urandom_range(0, 1);
         performance_events = {$urandom, $urandom};
         counters_clear     = ($urandom_range(0, 29) == 0);
         write_enable       = ($urandom_range(0, 9) < 6);
         data_pkt           = rnd_data();
         tlast_in           = ($urandom_range(0, 9) == 0);
         M_AXIS_tready      = $urandom_range(0, 1);
         tick();
      end
      rst = 1'b0;
      idle_inputs();
      M_AXIS_tready = 1'b1;
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
